// File: rtl/sbox_chaos_gen.sv
// Streams a 256-entry byte permutation for a downstream subbytes stage.
// Define SBOXGEN_CHAOS_EN for the logistic-map generator with FILL fallback.
module sbox_chaos_gen #(
  parameter int SBOX_WIDTH   = 8,
  parameter int SBOX_DEPTH   = 256,
  parameter int REJECT_LIMIT = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           seed,
  output logic                  sbox_valid,
  output logic [SBOX_WIDTH-1:0] sbox_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(SBOX_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SBOX_DEPTH);

`ifdef SBOXGEN_CHAOS_EN

  localparam int RW = $clog2(REJECT_LIMIT + 1);
  localparam logic [RW-1:0] REJ_TOP = RW'(REJECT_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FILL, S_DONE
  } state_t;

  state_t                  state;
  logic [31:0]             x;
  logic [SBOX_DEPTH-1:0]   used;
  logic [CW-1:0]           cnt;
  logic [RW-1:0]           rej;
  logic [SBOX_WIDTH-1:0]   p;

  logic [32:0]             omx;
  logic [64:0]             prod;
  logic [34:0]             shr;
  logic [31:0]             x_nxt;
  logic [SBOX_WIDTH-1:0]   cand;

  // Q0.32 logistic step with saturation of the 2^32 corner
  always_comb begin
    omx   = 33'h1_0000_0000 - {1'b0, x};
    prod  = 65'(x) * 65'(omx);
    shr   = 35'(prod >> 30);
    x_nxt = (|shr[34:32]) ? 32'hFFFF_FFFF
                          : shr[31:0];
    cand  = x[23:16] ^ x[7:0];
  end

  // Generator FSM: rejection sampling, then linear fill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      x          <= '0;
      used       <= '0;
      cnt        <= '0;
      rej        <= '0;
      p          <= '0;
      sbox_valid <= 1'b0;
      sbox_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          sbox_valid <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            x     <= (seed == 32'd0) ? 32'h6A09E667
                                     : seed;
            used  <= '0;
            cnt   <= '0;
            rej   <= '0;
            p     <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == LAST) begin
            sbox_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            x <= x_nxt;
            if (!used[cand]) begin
              used[cand] <= 1'b1;
              sbox_out   <= cand;
              sbox_valid <= 1'b1;
              cnt        <= cnt + 1'b1;
              rej        <= '0;
            end else begin
              sbox_valid <= 1'b0;
              rej        <= rej + 1'b1;
              if (rej == REJ_TOP) begin
                p     <= '0;
                state <= S_FILL;
              end
            end
          end
        end
        S_FILL: begin
          if (cnt == LAST) begin
            sbox_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            p <= p + 1'b1;
            if (!used[p]) begin
              used[p]    <= 1'b1;
              sbox_out   <= p;
              sbox_valid <= 1'b1;
              cnt        <= cnt + 1'b1;
            end else begin
              sbox_valid <= 1'b0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`else

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DONE
  } state_t;

  state_t                state;
  logic [SBOX_WIDTH-1:0] key;
  logic [CW-1:0]         cnt;
  logic                  unused_seed;

  assign unused_seed = ^seed[31:SBOX_WIDTH];

  // Plain XOR-keyed identity stream, first byte on the start edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      key        <= '0;
      cnt        <= '0;
      sbox_valid <= 1'b0;
      sbox_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          sbox_valid <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            key        <= seed[SBOX_WIDTH-1:0];
            sbox_out   <= seed[SBOX_WIDTH-1:0];
            sbox_valid <= 1'b1;
            cnt        <= CW'(1);
            busy       <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == LAST) begin
            sbox_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            sbox_out   <= SBOX_WIDTH'(cnt) ^ key;
            sbox_valid <= 1'b1;
            cnt        <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_sbox_chaos_gen.sv
// Randomized directed bench for sbox_chaos_gen.
// Expected streams come from a queue-based model of the generation rules.
module tb_sbox_chaos_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] seed;
  logic        sbox_valid;
  logic [7:0]  sbox_out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] keep_q[$];
  int first_v, last_v, done_cnt, done_cyc, busy_cnt;
  logic busy_at_done;
  int exp_first, exp_last, exp_done;

  always #5 clk = ~clk;

  sbox_chaos_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .seed       (seed),
    .sbox_valid (sbox_valid),
    .sbox_out   (sbox_out),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lmap(input logic [31:0] x);
    logic [63:0] pr;
    pr = 64'(x) * (64'h1_0000_0000 - 64'(x));
    pr = pr >> 30;
    return (pr > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : pr[31:0];
  endfunction

  task automatic model(input logic [31:0] s);
    exp_q.delete();
`ifdef SBOXGEN_CHAOS_EN
    begin
      bit used[256];
      int rej, r, f;
      logic [31:0] x;
      logic [7:0] c;
      rej = 0; r = 0; f = 0;
      for (int i = 0; i < 256; i++) used[i] = 1'b0;
      x = (s == 32'd0) ? 32'h6A09E667 : s;
      while (exp_q.size() < 256 && rej < 256) begin
        r++;
        c = x[23:16] ^ x[7:0];
        x = lmap(x);
        if (!used[c]) begin
          used[c] = 1'b1;
          exp_q.push_back(c);
          rej = 0;
        end else begin
          rej++;
        end
      end
      for (int q = 0; q < 256 && exp_q.size() < 256; q++) begin
        f++;
        if (!used[q]) begin
          used[q] = 1'b1;
          exp_q.push_back(8'(q));
        end
      end
      exp_first = 2;
      exp_last  = r + f + 1;
      exp_done  = r + f + 2;
    end
`else
    for (int i = 0; i < 256; i++)
      exp_q.push_back(8'(i) ^ s[7:0]);
    exp_first = 1;
    exp_last  = 256;
    exp_done  = 257;
`endif
  endtask

  task automatic collect(input logic [31:0] s,
                         input bit hammer,
                         input int budget);
    got.delete();
    first_v = -1; last_v = -1;
    done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(posedge clk);
    #1;
    if (!hammer) start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      seed = $urandom;
      if (sbox_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        got.push_back(sbox_out);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = k;
          busy_at_done = busy;
        end
        start = 1'b0;
      end
      if (done_cyc > 0 && k >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  function automatic int distinct(input logic [7:0] q[$]);
    bit seen[256];
    int n = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    foreach (q[i]) begin
      if (!seen[q[i]]) n++;
      seen[q[i]] = 1'b1;
    end
    return n;
  endfunction

  task automatic check_run(input string tag, input logic [31:0] s);
    int mm = 0;
    model(s);
    chk({tag, "_count"}, got.size(), 256);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) mm++;
    chk({tag, "_byte_mismatches"}, mm, 0);
    chk({tag, "_distinct"}, distinct(got), 256);
    chk({tag, "_first_valid_cyc"}, first_v, exp_first);
    chk({tag, "_last_valid_cyc"}, last_v, exp_last);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_done - 1);
  endtask

  initial begin
    logic [31:0] s;
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    seed    = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", sbox_valid, 0);
    chk("rst_out", sbox_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", sbox_valid, 0);

`ifdef SBOXGEN_CHAOS_EN
    collect(32'hC000_0000, 1'b0, 20000);
    check_run("fixed", 32'hC000_0000);
    chk("fixed_b0", got[0], 8'h00);
    chk("fixed_b1", got[1], 8'h01);
    chk("fixed_b255", got[255], 8'hFF);
    chk("fixed_last_cyc", last_v, 2 + 257 + 255);

    collect(32'd0, 1'b0, 20000);
    check_run("seed0", 32'd0);
    keep_q = got;
    collect(32'h6A09E667, 1'b0, 20000);
    check_run("seed_iv", 32'h6A09E667);
    n = 0;
    for (int i = 0; i < 256; i++)
      if (keep_q[i] !== got[i]) n++;
    chk("seed0_eq_iv", n, 0);

    collect(32'd1, 1'b0, 20000);
    check_run("seed1", 32'd1);
    collect(32'h1234_5678, 1'b0, 20000);
    check_run("seed_1234", 32'h1234_5678);
`else
    collect(32'h0000_00A5, 1'b0, 400);
    check_run("a5", 32'h0000_00A5);
    chk("a5_b0", got[0], 8'hA5);
    chk("a5_b1", got[1], 8'hA4);
    chk("a5_b2", got[2], 8'hA7);
    chk("a5_b255", got[255], 8'h5A);
`endif

    for (int r = 0; r < 3; r++) begin
      s = $urandom;
      collect(s, 1'b0, 20000);
      check_run("rand", s);
    end

    s = $urandom;
    collect(s, 1'b1, 20000);
    check_run("hammer", s);
    repeat (3) @(negedge clk);
    chk("hammer_idle_busy", busy, 0);

    s = $urandom;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 20000 && n < 100; k++) begin
      @(negedge clk);
      if (sbox_valid) n++;
    end
    chk("pre_reset_count", n, 100);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", sbox_valid, 0);
    chk("arst_out", sbox_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (sbox_valid) n++;
    end
    chk("arst_no_pulses", n, 0);
    reset_n = 1'b1;
    s = $urandom;
    collect(s, 1'b0, 20000);
    check_run("restart", s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
